// File: rtl/coeff_bank_store.sv
// Double-buffered coefficient store: one bank serves reads while the
// other is loaded; a bank swap is deferred until a read-free cycle.
module coeff_bank_store #(
  parameter int NTAPS = 16,
  parameter int CW    = 12,
  localparam int AW   = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [CW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_err,
  input  logic          swap_req,
  output logic          swap_done,
  output logic          active_bank,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data,
  output logic          rd_valid
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL,
    SWAP
  } state_t;

  localparam bit        USE_DEF = (NTAPS == 16) && (CW == 12);
  localparam logic [AW:0] LAST_C = (AW+1)'(NTAPS - 1);
  localparam logic [AW:0] NT_C   = (AW+1)'(NTAPS);

  function automatic int def_coef(input int i);
    int v;
    v = 0;
    case (i)
      0:  v = -15;
      1:  v = -28;
      2:  v = -22;
      3:  v = 23;
      4:  v = 106;
      5:  v = 199;
      6:  v = 263;
      7:  v = 272;
      8:  v = 213;
      9:  v = 99;
      10: v = -33;
      11: v = -144;
      12: v = -205;
      13: v = -198;
      14: v = -127;
      15: v = -3;
      default: v = 0;
    endcase
    return v;
  endfunction

  logic [CW-1:0] bank [2][NTAPS];
  state_t        state;
  logic [AW:0]   cnt;
  logic          shadow;
  logic          accept;
  logic          in_range;

  assign shadow   = ~active_bank;
  assign ld_ready = (state == IDLE) || (state == LOAD);
  assign accept   = ld_valid && ld_ready;
  assign in_range = ({1'b0, rd_addr} < NT_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      active_bank <= 1'b0;
      ld_err      <= 1'b0;
      swap_done   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NTAPS; i++) begin
          bank[b][i] <= USE_DEF ? CW'(def_coef(i)) : '0;
        end
      end
    end else begin
      ld_err    <= 1'b0;
      swap_done <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          if (accept) begin
            bank[shadow][cnt[AW-1:0]] <= ld_data;
            if (cnt == LAST_C) begin
              // a missing last flag still completes the set
              state  <= FULL;
              cnt    <= '0;
              ld_err <= !ld_last;
            end else if (ld_last) begin
              state  <= IDLE;
              cnt    <= '0;
              ld_err <= 1'b1;
            end else begin
              state <= LOAD;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (swap_req) state <= SWAP;
        end
        SWAP: begin
          if (!rd_en) begin
            active_bank <= shadow;
            swap_done   <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= in_range ? bank[active_bank][rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_coeff_bank_store.sv
// Bench for coeff_bank_store: table sweep, directed load/swap
// sequences and randomized traffic against a transaction-level model.
module tb_coeff_bank_store;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        ld_valid = 0, ld_last = 0, swap_req = 0, rd_en = 0;
  logic [11:0] ld_data = 0;
  logic [3:0]  rd_addr = 0;
  logic        ld_ready, ld_err, swap_done, active_bank, rd_valid;
  logic signed [11:0] rd_data;

  logic        rd_en10 = 0;
  logic [3:0]  rd_addr10 = 0;
  logic        ld_ready10, ld_err10, swap_done10, active10, rd_valid10;
  logic signed [11:0] rd_data10;

  always #5 clk = ~clk;

  coeff_bank_store dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .ld_err(ld_err),
    .swap_req(swap_req), .swap_done(swap_done),
    .active_bank(active_bank),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  coeff_bank_store #(.NTAPS(10)) dut10 (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(1'b0), .ld_ready(ld_ready10),
    .ld_data(12'd0), .ld_last(1'b0), .ld_err(ld_err10),
    .swap_req(1'b0), .swap_done(swap_done10),
    .active_bank(active10),
    .rd_en(rd_en10), .rd_addr(rd_addr10),
    .rd_data(rd_data10), .rd_valid(rd_valid10)
  );

  localparam int DEF [16] = '{-15, -28, -22, 23, 106, 199, 263, 272,
                              213, 99, -33, -144, -205, -198, -127, -3};

  typedef struct {
    logic [3:0] addr;
    int         exp;
  } vec_t;

  vec_t tbl [16];

  int n_chk = 0;
  int n_fail = 0;

  // model: bank contents, active index, load progress
  int mbank [2][16];
  int mact;
  int mcnt;
  bit mfull;
  int last_rd;
  int vals [17];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) mbank[b][i] = DEF[i];
    mact = 0;
    mcnt = 0;
    mfull = 0;
    last_rd = 0;
  endtask

  task automatic tick();
    bit en;
    int e;
    en = rd_en;
    e = mbank[mact][rd_addr];
    @(posedge clk);
    #1;
    if (en) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, e);
      last_rd = e;
    end else begin
      chk("rd_valid_low", rd_valid, 0);
      chk("rd_data_hold", rd_data, last_rd);
    end
  endtask

  // drives n beats of vals[]; last_at < 0 means no ld_last flag
  task automatic do_load(input int n, input int last_at, input bit rd_rand);
    bit acc, err;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1;
      ld_data  = 12'(vals[i]);
      ld_last  = (i == last_at);
      rd_en    = rd_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_addr  = 4'($urandom);
      chk("ld_ready", ld_ready, !mfull);
      acc = !mfull;
      err = acc && ((ld_last && mcnt < 15) || (!ld_last && mcnt == 15));
      if (acc) begin
        mbank[1 - mact][mcnt] = vals[i];
        if (mcnt == 15) begin
          mfull = 1;
          mcnt = 0;
        end else if (ld_last) mcnt = 0;
        else mcnt++;
      end
      tick();
      chk("ld_err", ld_err, err);
    end
    ld_valid = 0;
    ld_last  = 0;
    rd_en    = 0;
  endtask

  // swap_req for one cycle, then rd_en held for hold-1 further cycles
  task automatic do_swap(input int hold);
    int old;
    old = mact;
    swap_req = 1;
    rd_en    = (hold > 0);
    rd_addr  = 4'($urandom);
    tick();
    swap_req = 0;
    chk("swap_early", swap_done, 0);
    chk("active_early", active_bank, old);
    for (int i = 1; i < hold; i++) begin
      rd_en   = 1;
      rd_addr = 4'($urandom);
      tick();
      chk("swap_hold", swap_done, 0);
      chk("active_hold", active_bank, old);
    end
    rd_en = 0;
    tick();
    if (mfull) begin
      mact = 1 - mact;
      mfull = 0;
    end
    chk("swap_done", swap_done, (mact != old));
    chk("active_bank", active_bank, mact);
    tick();
    chk("swap_done_clr", swap_done, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 4'(i);
      tbl[i].exp  = DEF[i];
    end
    model_reset();

    #1 rst_n = 0;
    #3;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_active", active_bank, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_ld_ready", ld_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      rd_en = 1;
      rd_addr = tbl[i].addr;
      tick();
      chk("tbl_data", rd_data, tbl[i].exp);
    end
    rd_en = 0;
    tick();

    for (int k = 0; k < 16; k++) vals[k] = k * 10;
    do_load(16, 15, 0);
    chk("full_ready", ld_ready, 0);
    do_swap(0);
    chk("req37_active", active_bank, 1);
    rd_en = 1;
    rd_addr = 7;
    tick();
    chk("req37_addr7", rd_data, 70);

    for (int k = 0; k < 16; k++) vals[k] = 500 + k;
    do_load(6, 5, 0);
    chk("short_ready", ld_ready, 1);
    tick();
    chk("short_err_clr", ld_err, 0);
    do_swap(0);
    chk("short_active", active_bank, 1);

    for (int k = 0; k < 16; k++) vals[k] = int'($urandom_range(0, 4095)) - 2048;
    do_load(16, 15, 1);
    do_swap(20);

    for (int k = 0; k < 17; k++) vals[k] = -(k * 7) - 1;
    do_load(16, -1, 1);
    chk("long_ready", ld_ready, 0);
    ld_valid = 1;
    ld_data = 12'(vals[16]);
    tick();
    chk("long_blocked_err", ld_err, 0);
    ld_valid = 0;
    do_swap(2);
    for (int a = 0; a < 16; a++) begin
      rd_en = 1;
      rd_addr = 4'(a);
      tick();
    end

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 6)) begin
          rd_en = 1'($urandom_range(0, 1));
          rd_addr = 4'($urandom);
          tick();
        end
      end else begin
        for (int k = 0; k < 16; k++) vals[k] = int'($urandom_range(0, 4095)) - 2048;
        do_load(16, 15, 1);
        do_swap(int'($urandom_range(0, 5)));
      end
    end

    for (int k = 0; k < 16; k++) vals[k] = 1000 + k;
    do_load(8, -1, 0);
    ld_valid = 1;
    ld_data = 12'(vals[8]);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_data", rd_data, 0);
    chk("mid_rst_active", active_bank, 0);
    chk("mid_rst_err", ld_err, 0);
    chk("mid_rst_swap", swap_done, 0);
    ld_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", ld_ready, 1);
    foreach (tbl[i]) begin
      rd_en = 1;
      rd_addr = tbl[i].addr;
      tick();
      chk("tbl2_data", rd_data, tbl[i].exp);
    end
    rd_en = 0;
    do_swap(0);
    chk("no_pending_swap", active_bank, 0);

    rd_en10 = 1;
    rd_addr10 = 12;
    @(posedge clk);
    #1;
    chk("n10_oor_data", rd_data10, 0);
    chk("n10_oor_valid", rd_valid10, 1);
    rd_addr10 = 3;
    @(posedge clk);
    #1;
    chk("n10_zero_def", rd_data10, 0);
    rd_en10 = 0;
    @(posedge clk);
    #1;
    chk("n10_valid_low", rd_valid10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
